// File: rtl/steel_clint_pkg.sv
// steel_clint_pkg: CLINT register offsets and the byte-lane merge helper
// shared by the CLINT and the data RAM model.
package steel_clint_pkg;

    localparam logic [15:0] MSIP_OFS        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFS = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFS = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFS    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFS    = 16'hBFFC;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  mask
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/steel_clint_if.sv
// steel_clint_if: core data-port signals seen by the CLINT.
// master = core side, slave = CLINT side.
interface steel_clint_if;

    logic [31:0] D_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_REQ;
    logic [3:0]  WR_MASK;
    logic        HIT;
    logic [31:0] RD_DATA;

    modport master (
        output D_ADDR, WR_DATA, WR_REQ, WR_MASK,
        input  HIT, RD_DATA
    );

    modport slave (
        input  D_ADDR, WR_DATA, WR_REQ, WR_MASK,
        output HIT, RD_DATA
    );

endinterface

// File: rtl/steel_clint_prescaler.sv
// steel_clint_prescaler: divides CLK into mtime ticks,
// TICK high in the last cycle of each PRESCALE-cycle period.
module steel_clint_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic TICK
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    assign TICK = (cnt == LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/steel_clint.sv
// steel_clint: core-local interruptor holding mtime, mtimecmp and msip,
// driving the machine timer and software interrupt requests.
module steel_clint
    import steel_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    steel_clint_if.slave       bus,
    output logic [63:0]        REAL_TIME,
    output logic               T_IRQ,
    output logic               S_IRQ
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        t_irq;
    logic [31:0] rd_data;
    logic [31:0] rd_word;
    logic        tick;
    logic        hit;
    logic        wr_en;
    logic [15:0] ofs;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        unused_addr_bits;

    steel_clint_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TICK    (tick)
    );

    assign hit   = (bus.D_ADDR[31:16] == BASE_ADDR[31:16]);
    assign ofs   = {bus.D_ADDR[15:2], 2'b00};
    assign wr_en = bus.WR_REQ & hit;

    // Byte offset within the word is irrelevant: all registers are word-wide.
    assign unused_addr_bits = &{1'b0, bus.D_ADDR[1:0]};

    assign sel_msip    = (ofs == MSIP_OFS);
    assign sel_cmp_lo  = (ofs == MTIMECMP_LO_OFS);
    assign sel_cmp_hi  = (ofs == MTIMECMP_HI_OFS);
    assign sel_time_lo = (ofs == MTIME_LO_OFS);
    assign sel_time_hi = (ofs == MTIME_HI_OFS);

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            sel_msip:    rd_word = {31'd0, msip};
            sel_cmp_lo:  rd_word = mtimecmp[31:0];
            sel_cmp_hi:  rd_word = mtimecmp[63:32];
            sel_time_lo: rd_word = mtime[31:0];
            sel_time_hi: rd_word = mtime[63:32];
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip     <= 1'b0;
            t_irq    <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_data <= hit ? rd_word : '0;
            t_irq   <= (mtime >= mtimecmp);

            if (wr_en && sel_msip && bus.WR_MASK[0]) begin
                msip <= bus.WR_DATA[0];
            end
            if (wr_en && sel_cmp_lo) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0],
                                              bus.WR_DATA, bus.WR_MASK);
            end
            if (wr_en && sel_cmp_hi) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32],
                                               bus.WR_DATA, bus.WR_MASK);
            end

            // A software write to mtime wins over the tick; no carry.
            if (wr_en && sel_time_lo) begin
                mtime[31:0] <= merge_bytes(mtime[31:0],
                                           bus.WR_DATA, bus.WR_MASK);
            end else if (wr_en && sel_time_hi) begin
                mtime[63:32] <= merge_bytes(mtime[63:32],
                                            bus.WR_DATA, bus.WR_MASK);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    assign bus.HIT     = hit;
    assign bus.RD_DATA = rd_data;
    assign REAL_TIME   = mtime;
    assign T_IRQ       = t_irq;
    assign S_IRQ       = msip;

endmodule
